// File: rtl/tile_pkg.sv
// tile_pkg: shared constants, derived widths and types for the tile coordinate tracker.
// Geometry: 40x40 pixel tiles on a 16x12 toroidal map over a 640x480 active raster.
// Types: tile_coord_t bundles a map position with the pixel offset inside that tile.
package tile_pkg;

  localparam int TILE_W   = 40;
  localparam int TILE_H   = 40;
  localparam int MAP_W    = 16;
  localparam int MAP_H    = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int TX_W = $clog2(MAP_W);
  localparam int RX_W = $clog2(TILE_W);
  localparam int TY_W = $clog2(MAP_H);
  localparam int RY_W = $clog2(TILE_H);

  typedef struct packed {
    logic [TX_W-1:0] tile_x;
    logic [TY_W-1:0] tile_y;
    logic [RX_W-1:0] rel_x;
    logic [RY_W-1:0] rel_y;
  } tile_coord_t;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } track_state_t;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: seeded pixel-in-tile / tile-in-map counter pair with toroidal wrap.
// Latency: new value visible the cycle after load_i/adv_i; load_i wins over adv_i.
// Ports: load_i/seed_*_i reseed, adv_i steps one pixel, tile_o/rel_o current position.
module wrap_counter #(
  parameter int TILE = 40,
  parameter int MAP  = 16,
  localparam int RW  = $clog2(TILE),
  localparam int TW  = $clog2(MAP)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [TW-1:0] seed_tile_i,
  input  logic [RW-1:0] seed_rel_i,
  output logic [TW-1:0] tile_o,
  output logic [RW-1:0] rel_o
);
  import tile_pkg::*;

  logic [TW-1:0] tile_q, tile_d;
  logic [RW-1:0] rel_q, rel_d;

  always_comb begin
    tile_d = tile_q;
    rel_d  = rel_q;
    if (load_i) begin
      tile_d = seed_tile_i;
      rel_d  = seed_rel_i;
    end else if (adv_i) begin
      if (rel_q == RW'(TILE - 1)) begin
        rel_d  = '0;
        tile_d = (tile_q == TW'(MAP - 1)) ? '0 : tile_q + TW'(1);
      end else begin
        rel_d = rel_q + RW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tile_q <= '0;
      rel_q  <= '0;
    end else begin
      tile_q <= tile_d;
      rel_q  <= rel_d;
    end
  end

  assign tile_o = tile_q;
  assign rel_o  = rel_q;

endmodule

// File: rtl/tile_coord_tracker.sv
// tile_coord_tracker: follows the VGA raster (DrawX/DrawY) with wrap counters and maps
// each pix_ce sample to map tile + in-tile offset, one cycle later; flags raster jumps.
// Ports: Clk/Reset, pix_ce + DrawX/DrawY sample, scroll_* seeds (used only when
// TILE_SCROLL_EN is defined), tile_x/tile_y/rel_x/rel_y, out_valid, desync pulse.
module tile_coord_tracker #(
  parameter int TILE_W   = 40,
  parameter int TILE_H   = 40,
  parameter int MAP_W    = 16,
  parameter int MAP_H    = 12,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 10
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       pix_ce,
  input  logic [COORD_W-1:0]         DrawX,
  input  logic [COORD_W-1:0]         DrawY,
  input  logic [$clog2(MAP_W)-1:0]   scroll_tx,
  input  logic [$clog2(TILE_W)-1:0]  scroll_rx,
  input  logic [$clog2(MAP_H)-1:0]   scroll_ty,
  input  logic [$clog2(TILE_H)-1:0]  scroll_ry,
  output logic [$clog2(MAP_W)-1:0]   tile_x,
  output logic [$clog2(MAP_H)-1:0]   tile_y,
  output logic [$clog2(TILE_W)-1:0]  rel_x,
  output logic [$clog2(TILE_H)-1:0]  rel_y,
  output logic                       out_valid,
  output logic                       desync
);
  import tile_pkg::*;

  track_state_t        state_q, state_d;
  tile_coord_t         scroll_q, scroll_in;
  tile_coord_t         cnt;
  logic [COORD_W-1:0]  prev_x_q, prev_y_q, prev_x_d, prev_y_d;
  logic                valid_q, valid_d;
  logic                desync_q, desync_d;
  logic                ld_x, ld_y, adv_x, adv_y;
  logic                frame_start, step_line, step_pix, same_pix;
  logic [$clog2(MAP_W)-1:0]  seed_tx;
  logic [$clog2(TILE_W)-1:0] seed_rx;

`ifdef TILE_SCROLL_EN
  assign scroll_in = '{tile_x: scroll_tx, tile_y: scroll_ty, rel_x: scroll_rx, rel_y: scroll_ry};
`else
  logic unused_scroll;
  assign unused_scroll = ^{scroll_tx, scroll_rx, scroll_ty, scroll_ry};
  assign scroll_in     = '0;
`endif

  assign frame_start = (DrawX == '0) && (DrawY == '0);
  assign step_line   = (DrawX == '0) && (DrawY == prev_y_q + COORD_W'(1));
  assign step_pix    = (DrawX == prev_x_q + COORD_W'(1)) && (DrawY == prev_y_q);
  assign same_pix    = (DrawX == prev_x_q) && (DrawY == prev_y_q);

  // Frame start seeds from the live scroll inputs (latched the same edge);
  // a line start reloads x from the values latched at frame start.
  assign seed_tx = frame_start ? scroll_in.tile_x : scroll_q.tile_x;
  assign seed_rx = frame_start ? scroll_in.rel_x  : scroll_q.rel_x;

  always_comb begin
    state_d  = state_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    valid_d  = valid_q;
    desync_d = 1'b0;
    ld_x     = 1'b0;
    ld_y     = 1'b0;
    adv_x    = 1'b0;
    adv_y    = 1'b0;
    if (pix_ce) begin
      if (frame_start) begin
        state_d = TRACK;
        ld_x    = 1'b1;
        ld_y    = 1'b1;
      end else if (state_q == TRACK) begin
        if (step_line) begin
          adv_y = 1'b1;
          ld_x  = 1'b1;
        end else if (step_pix) begin
          adv_x = 1'b1;
        end else if (!same_pix) begin
          desync_d = 1'b1;
          state_d  = SYNC;
        end
      end
      if (state_d == TRACK) begin
        prev_x_d = DrawX;
        prev_y_d = DrawY;
      end
      valid_d = (state_d == TRACK) && (DrawX < COORD_W'(H_ACTIVE)) && (DrawY < COORD_W'(V_ACTIVE));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= SYNC;
      scroll_q <= '0;
      prev_x_q <= '0;
      prev_y_q <= '0;
      valid_q  <= 1'b0;
      desync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      valid_q  <= valid_d;
      desync_q <= desync_d;
      if (pix_ce && frame_start) scroll_q <= scroll_in;
    end
  end

  wrap_counter #(.TILE(TILE_W), .MAP(MAP_W)) u_x (
    .Clk(Clk), .Reset(Reset), .load_i(ld_x), .adv_i(adv_x),
    .seed_tile_i(seed_tx), .seed_rel_i(seed_rx),
    .tile_o(cnt.tile_x), .rel_o(cnt.rel_x)
  );

  wrap_counter #(.TILE(TILE_H), .MAP(MAP_H)) u_y (
    .Clk(Clk), .Reset(Reset), .load_i(ld_y), .adv_i(adv_y),
    .seed_tile_i(scroll_in.tile_y), .seed_rel_i(scroll_in.rel_y),
    .tile_o(cnt.tile_y), .rel_o(cnt.rel_y)
  );

  // Counters run through blanking; coordinates are zeroed whenever not valid.
  assign tile_x    = valid_q ? cnt.tile_x : '0;
  assign tile_y    = valid_q ? cnt.tile_y : '0;
  assign rel_x     = valid_q ? cnt.rel_x  : '0;
  assign rel_y     = valid_q ? cnt.rel_y  : '0;
  assign out_valid = valid_q;
  assign desync    = desync_q;

endmodule

// File: tb/tb_tile_coord_tracker.sv
module tb_tile_coord_tracker;
  localparam int TW = 40, TH = 40, MW = 16, MH = 12, HA = 640, VA = 480;
  localparam int V_TOTAL = 525;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       pix_ce;
  logic [9:0] DrawX, DrawY;
  logic [3:0] scroll_tx, scroll_ty;
  logic [5:0] scroll_rx, scroll_ry;
  logic [3:0] tile_x, tile_y;
  logic [5:0] rel_x, rel_y;
  logic       out_valid, desync;

  tile_coord_tracker dut (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .DrawX(DrawX), .DrawY(DrawY),
    .scroll_tx(scroll_tx), .scroll_rx(scroll_rx), .scroll_ty(scroll_ty), .scroll_ry(scroll_ry),
    .tile_x(tile_x), .tile_y(tile_y), .rel_x(rel_x), .rel_y(rel_y),
    .out_valid(out_valid), .desync(desync)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int v;
    int tx;
    int ty;
    int rx;
    int ry;
    int ds;
  } exp_t;

  exp_t q[$];
  exp_t last_exp = '{0, 0, 0, 0, 0, 0};
  int   total = 0;
  int   bad   = 0;

  // Reference model state: tracking flag, last accepted sample, latched scroll.
  bit trk = 0;
  int px = 0, py = 0;
  int ltx = 0, lrx = 0, lty = 0, lry = 0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  task automatic compare(input exp_t e);
    check("out_valid", out_valid, e.v);
    check("tile_x", tile_x, e.tx);
    check("tile_y", tile_y, e.ty);
    check("rel_x", rel_x, e.rx);
    check("rel_y", rel_y, e.ry);
    check("desync", desync, e.ds);
  endtask

  // Monitor: a pix_ce edge presents a fresh result one cycle later; otherwise outputs hold.
  initial begin
    bit ce_s;
    exp_t e;
    forever begin
      @(posedge Clk);
      ce_s = pix_ce && !Reset;
      @(negedge Clk);
      if (ce_s) begin
        if (q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          compare(e);
          last_exp    = e;
          last_exp.ds = 0;
        end
      end else begin
        compare(last_exp);
      end
    end
  end

  task automatic randomize_scroll();
    scroll_tx = 4'($urandom_range(0, MW - 1));
    scroll_rx = 6'($urandom_range(0, TW - 1));
    scroll_ty = 4'($urandom_range(0, MH - 1));
    scroll_ry = 6'($urandom_range(0, TH - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      pix_ce = 1'b0;
      DrawX  = 10'($urandom_range(0, 799));
      DrawY  = 10'($urandom_range(0, 524));
      randomize_scroll();
    end
  endtask

  // Issue one raster sample; the model decides the expected mapping from absolute
  // pixel position: (scroll_tile*TILE + scroll_rel + X) split into tile/rel, mod map.
  task automatic sample(input int x, input int y, input bit keep_scroll);
    exp_t e;
    int ax, ay;
    bit fs;
    @(negedge Clk);
    if (!keep_scroll) randomize_scroll();
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    pix_ce = 1'b1;
    fs = (x == 0) && (y == 0);
    e  = '{0, 0, 0, 0, 0, 0};
    if (fs) begin
      trk = 1;
`ifdef TILE_SCROLL_EN
      ltx = scroll_tx; lrx = scroll_rx; lty = scroll_ty; lry = scroll_ry;
`else
      ltx = 0; lrx = 0; lty = 0; lry = 0;
`endif
    end else if (trk) begin
      if (!((x == 0 && y == py + 1) || (x == px + 1 && y == py) || (x == px && y == py))) begin
        e.ds = 1;
        trk  = 0;
      end
    end
    if (trk) begin
      px = x;
      py = y;
    end
    if (trk && x < HA && y < VA) begin
      ax   = ltx * TW + lrx + x;
      ay   = lty * TH + lry + y;
      e.v  = 1;
      e.tx = (ax / TW) % MW;
      e.rx = ax % TW;
      e.ty = (ay / TH) % MH;
      e.ry = ay % TH;
    end
    q.push_back(e);
    if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
  endtask

  task automatic do_reset();
    idle(3);
    #2;
    Reset    = 1'b1;
    last_exp = '{0, 0, 0, 0, 0, 0};
    trk      = 0;
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_coord", int'({tile_x, tile_y, rel_x, rel_y}), 0);
    check("reset_desync", desync, 0);
    idle(2);
    #2;
    Reset = 1'b0;
  endtask

  // One frame: line 0 scanned to X=45, line 479 scanned into blanking, others short.
  // jump_at_x>=0 forces a jump from that X to 100 on line 0; reset_line>=0 resets mid-frame.
  task automatic frame(input bit directed_scroll, input int jump_at_x, input int reset_line,
                       input bit rand_jump);
    int len;
    for (int y = 0; y < V_TOTAL; y++) begin
      if (y == 0) len = 46;
      else if (y == 479) len = 646;
      else len = $urandom_range(1, 3);
      for (int x = 0; x < len; x++) begin
        if (y == 0 && x == 0 && directed_scroll) begin
          scroll_tx = 4'd15; scroll_rx = 6'd30; scroll_ty = 4'd2; scroll_ry = 6'd5;
          sample(0, 0, 1'b1);
        end else begin
          sample(x, y, 1'b0);
        end
        if ($urandom_range(0, 7) == 0) sample(x, y, 1'b0);
        if (y == 0 && x == jump_at_x) begin
          sample(100, 0, 1'b0);
          for (int j = 101; j < 104; j++) sample(j, 0, 1'b0);
        end
        if (rand_jump && y == 300 && x == 0) sample($urandom_range(5, 600), 300, 1'b0);
      end
      if (y == reset_line) do_reset();
    end
  endtask

  initial begin
    Reset  = 1'b1;
    pix_ce = 1'b0;
    DrawX  = '0;
    DrawY  = '0;
    randomize_scroll();
    #1;
    check("por_valid", out_valid, 0);
    check("por_desync", desync, 0);
    repeat (3) @(negedge Clk);
    #2;
    Reset = 1'b0;

    // Samples before any frame start must be ignored.
    sample(7, 3, 1'b0);
    sample(8, 3, 1'b0);
    frame(1'b1, -1, -1, 1'b0);
    frame(1'b0, 5, -1, 1'b0);
    frame(1'b0, -1, 200, 1'b0);
    frame(1'b0, -1, -1, 1'b1);
    frame(1'b0, -1, -1, 1'b0);
    sample(0, 0, 1'b0);
    idle(4);
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/tile_coord_tracker.md
Name: tile_coord_tracker

Overview:
- Sequential, parametrised successor to the combinational pixel-to-tile coordinate mapper in the 2DMC video path.
- Tracks the VGA raster with wrap-around counters instead of comparator ladders, and adds a per-frame scroll offset, toroidal map wrap, desync detection and registered outputs.
- Sits between the VGA controller (DrawX/DrawY) and the tile-map ROM/sprite lookup.

Parameters:
- TILE_W, 40, tile width in pixels (≥2).
- TILE_H, 40, tile height in pixels (≥2).
- MAP_W, 16, map width in tiles.
- MAP_H, 12, map height in tiles.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- COORD_W, 10, DrawX/DrawY width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- pix_ce  in  1  pixel strobe; one raster sample per asserted cycle.
- DrawX  in  COORD_W  raster column.
- DrawY  in  COORD_W  raster row.
- scroll_tx  in  $clog2(MAP_W)  scroll tile offset x.
- scroll_rx  in  $clog2(TILE_W)  scroll pixel offset x within tile (must be < TILE_W).
- scroll_ty  in  $clog2(MAP_H)  scroll tile offset y.
- scroll_ry  in  $clog2(TILE_H)  scroll pixel offset y within tile (must be < TILE_H).
- tile_x  out  $clog2(MAP_W)  map column of the sampled pixel.
- tile_y  out  $clog2(MAP_H)  map row of the sampled pixel.
- rel_x  out  $clog2(TILE_W)  column within the tile.
- rel_y  out  $clog2(TILE_H)  row within the tile.
- out_valid  out  1  outputs are meaningful.
- desync  out  1  one-cycle pulse on a raster discontinuity.

Behaviour:
- Reset is asynchronous. All outputs and counters go to 0, the state machine goes to SYNC, and the latched scroll values go to 0.
- State machine: SYNC -> TRACK on a pix_ce sample with DrawX==0 && DrawY==0. TRACK -> SYNC on a discontinuity. TRACK -> TRACK on a frame start, which reseeds the counters.
- Everything updates only when pix_ce=1. Registers hold when pix_ce=0.
- Latency: outputs reflect the sample taken at the previous pix_ce edge (1 cycle).
- Frame start (X==0, Y==0, any state):
  - latch the four scroll inputs;
  - cx_tile=scroll_tx, cx_rel=scroll_rx;
  - cy_tile=scroll_ty, cy_rel=scroll_ry.
- In TRACK, with prev_x/prev_y being the last accepted sample:
  - X==0 && Y==prev_y+1: advance y; reload x from the latched scroll.
  - X==prev_x+1 && Y==prev_y: advance x.
  - X==prev_x && Y==prev_y: hold (repeated sample is legal).
  - Anything else: desync=1 for one cycle, state=SYNC, out_valid=0.
- Advance rule, x: rel==TILE_W-1 -> rel=0 and tile increments. Tile==MAP_W-1 -> tile=0 (toroidal wrap). y follows the same rule with TILE_H and MAP_H.
- Blanking: counters keep advancing through X≥H_ACTIVE and Y≥V_ACTIVE. No wrap errors are possible.
- out_valid = TRACK && X<H_ACTIVE && Y<V_ACTIVE for the sampled pixel.
- When out_valid=0, tile_x/tile_y/rel_x/rel_y are driven to 0.
- In SYNC, all non-frame-start samples are ignored and no further desync pulses occur.
- Scroll inputs are sampled only at frame start; mid-frame changes have no effect.
- Reset mid-line: the block is invalid until the next frame start.

Optional Feature:
- Macro: TILE_SCROLL_EN.
- Defined: scroll inputs are latched and used as seeds, as above.
- Undefined: scroll ports remain but are ignored, and all seeds are 0. The mapping is then exactly X/TILE_W, X%TILE_W, Y/TILE_H, Y%TILE_H within the active area.

Decomposition:
- Package tile_pkg holds:
  - constants TILE_W, TILE_H, MAP_W, MAP_H, H_ACTIVE, V_ACTIVE;
  - derived widths TX_W, RX_W, TY_W, RY_W;
  - typedef tile_coord_t, a struct of tile_x, tile_y, rel_x, rel_y;
  - enum track_state_t {SYNC, TRACK}.
- Sub-module wrap_counter (parameters TILE, MAP): seeded rel/tile counter pair with advance and load. Instantiated once for x and once for y.

Test Plan:
- Reset asserted mid-frame -> all outputs 0, out_valid 0; after release, no valid output until X=0,Y=0.
- No scroll, frame start, then X=0..45 on Y=0 -> X=39 gives tile_x=0, rel_x=39; X=40 gives tile_x=1, rel_x=0.
- Vertical step: lines 39->40 at X=0 -> tile_y=1, rel_y=0. Line 479 X=639 -> tile_y=11, rel_y=39, tile_x=15, rel_x=39.
- TILE_SCROLL_EN, scroll_tx=15, scroll_rx=30:
  - X=9 -> tile_x=15, rel_x=39;
  - X=10 -> tile_x=0, rel_x=0.
- Jump X 5->100 on the same line -> desync pulses once, out_valid=0 for the rest of the frame, recovery at the next X=0,Y=0.
- X=640 (blank) -> out_valid=0 and coordinates 0. pix_ce low for 3 cycles -> outputs held.
